// File: rtl/key_entry_pkg.sv
// Shared scan-code constants, FSM states and keystroke classes for the PS/2 key-entry block.
// Pure declarations: no logic, no latency, no flow control.
package key_entry_pkg;

    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic {
        ST_EDIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        KC_NONE  = 3'd0,
        KC_HEX   = 3'd1,
        KC_ENTER = 3'd2,
        KC_BKSP  = 3'd3,
        KC_ESC   = 3'd4
    } key_class_t;

endpackage

// File: rtl/key_entry_ps2_hex_decode.sv
// Combinational PS/2 set-2 make-code classifier: hex nibble, Enter, Backspace, Esc or none.
// Latency 0 (pure decode); no backpressure.
module ps2_hex_decode
    import key_entry_pkg::*;
(
    input  logic [7:0]  code,
    output logic [3:0]  nibble,
    output key_class_t  key_class
);

    always_comb begin
        nibble    = 4'h0;
        key_class = KC_HEX;
        case (code)
            8'h45: nibble = 4'h0;
            8'h16: nibble = 4'h1;
            8'h1E: nibble = 4'h2;
            8'h26: nibble = 4'h3;
            8'h25: nibble = 4'h4;
            8'h2E: nibble = 4'h5;
            8'h36: nibble = 4'h6;
            8'h3D: nibble = 4'h7;
            8'h3E: nibble = 4'h8;
            8'h46: nibble = 4'h9;
            8'h1C: nibble = 4'hA;
            8'h32: nibble = 4'hB;
            8'h21: nibble = 4'hC;
            8'h23: nibble = 4'hD;
            8'h24: nibble = 4'hE;
            8'h2B: nibble = 4'hF;
            SC_ENTER: key_class = KC_ENTER;
            SC_BKSP:  key_class = KC_BKSP;
            SC_ESC:   key_class = KC_ESC;
            default:  key_class = KC_NONE;
        endcase
    end

endmodule

// File: rtl/key_entry_controller.sv
// Hex key entry from PS/2 scan bytes: edit buffer, commit on Enter, hold until KEY_ACK.
// Latency 1 cycle, all outputs registered; no backpressure on SCAN_VALID, KEY_READY held until KEY_ACK.
module key_entry_controller
    import key_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int KEY_W      = 4 * NUM_DIGITS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       SCAN_CODE,
    input  logic             SCAN_VALID,
    input  logic             KEY_ACK,
    output logic [KEY_W-1:0] EDIT_BUF,
    output logic [2:0]       DIGIT_COUNT,
    output logic [KEY_W-1:0] KEY_OUT,
    output logic             KEY_READY,
    output logic             ERR
);

    localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

    state_t           state_q, state_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic [KEY_W-1:0] edit_buf_q, edit_buf_d;
    logic [2:0]       digit_count_q, digit_count_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_ready_q, key_ready_d;
    logic             err_q, err_d;

    logic [3:0]       nibble;
    key_class_t       key_class;
    logic             keystroke;

    ps2_hex_decode u_decode (
        .code      (SCAN_CODE),
        .nibble    (nibble),
        .key_class (key_class)
    );

    always_comb begin
        state_d       = state_q;
        brk_d         = brk_q;
        ext_d         = ext_q;
        edit_buf_d    = edit_buf_q;
        digit_count_d = digit_count_q;
        key_out_d     = key_out_q;
        key_ready_d   = key_ready_q;
        err_d         = 1'b0;
        keystroke     = 1'b0;

        // Prefix flags track in every state; only a clean make code is a keystroke.
        if (SCAN_VALID) begin
            if (SCAN_CODE == SC_BRK) begin
                brk_d = 1'b1;
            end else if (SCAN_CODE == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                brk_d     = 1'b0;
                ext_d     = 1'b0;
                keystroke = !brk_q && !ext_q;
            end
        end

        case (state_q)
            ST_EDIT: begin
                if (keystroke) begin
                    case (key_class)
                        KC_HEX: begin
                            if (digit_count_q < FULL_CNT) begin
                                edit_buf_d    = {edit_buf_q[KEY_W-5:0], nibble};
                                digit_count_d = digit_count_q + 3'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        KC_BKSP: begin
                            if (digit_count_q != 3'd0) begin
                                edit_buf_d    = {4'h0, edit_buf_q[KEY_W-1:4]};
                                digit_count_d = digit_count_q - 3'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        KC_ESC: begin
                            edit_buf_d    = '0;
                            digit_count_d = 3'd0;
                        end
                        KC_ENTER: begin
                            if (digit_count_q == FULL_CNT) begin
                                key_out_d   = edit_buf_q;
                                key_ready_d = 1'b1;
                                state_d     = ST_HOLD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_HOLD: begin
                // Keystrokes are dropped here, even one arriving with the ack.
                if (KEY_ACK) begin
                    key_ready_d   = 1'b0;
                    edit_buf_d    = '0;
                    digit_count_d = 3'd0;
                    state_d       = ST_EDIT;
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_EDIT;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            edit_buf_q    <= '0;
            digit_count_q <= 3'd0;
            key_out_q     <= '0;
            key_ready_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            edit_buf_q    <= edit_buf_d;
            digit_count_q <= digit_count_d;
            key_out_q     <= key_out_d;
            key_ready_q   <= key_ready_d;
            err_q         <= err_d;
        end
    end

    assign EDIT_BUF    = edit_buf_q;
    assign DIGIT_COUNT = digit_count_q;
    assign KEY_OUT     = key_out_q;
    assign KEY_READY   = key_ready_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_key_entry_controller.sv
// Bench for key_entry_controller: directed scenarios plus randomized bytes against a digit-queue model.
module tb_key_entry_controller;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   scan_code = 8'h00;
    logic         scan_valid = 1'b0;
    logic         key_ack = 1'b0;
    logic [W-1:0] edit_buf;
    logic [2:0]   digit_count;
    logic [W-1:0] key_out;
    logic         key_ready;
    logic         err;

    int tests_run    = 0;
    int tests_failed = 0;

    key_entry_controller #(.NUM_DIGITS(N), .KEY_W(W)) dut (
        .CLK         (clk),
        .RST         (rst),
        .SCAN_CODE   (scan_code),
        .SCAN_VALID  (scan_valid),
        .KEY_ACK     (key_ack),
        .EDIT_BUF    (edit_buf),
        .DIGIT_COUNT (digit_count),
        .KEY_OUT     (key_out),
        .KEY_READY   (key_ready),
        .ERR         (err)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits kept as a queue of nibble values.
    int           m_digits[$];
    bit           m_hold, m_brk, m_ext, m_ready, m_err;
    logic [W-1:0] m_key;

    // Returns 0..15 for hex keys, 16 Enter, 17 Backspace, 18 Esc, -1 otherwise.
    function automatic int key_value(input logic [7:0] c);
        case (c)
            8'h45: return 0;   8'h16: return 1;   8'h1E: return 2;   8'h26: return 3;
            8'h25: return 4;   8'h2E: return 5;   8'h36: return 6;   8'h3D: return 7;
            8'h3E: return 8;   8'h46: return 9;   8'h1C: return 10;  8'h32: return 11;
            8'h21: return 12;  8'h23: return 13;  8'h24: return 14;  8'h2B: return 15;
            8'h5A: return 16;  8'h66: return 17;  8'h76: return 18;
            default: return -1;
        endcase
    endfunction

    function automatic logic [W-1:0] m_buf();
        logic [W-1:0] v;
        v = '0;
        foreach (m_digits[i]) v = (v << 4) | W'(m_digits[i]);
        return v;
    endfunction

    task automatic model_step(input logic [7:0] c, input bit v, input bit ack, input bit r);
        bit was_hold;
        bit ks;
        int k;
        if (r) begin
            m_digits.delete();
            m_hold = 0; m_brk = 0; m_ext = 0; m_ready = 0; m_err = 0; m_key = '0;
            return;
        end
        m_err    = 0;
        was_hold = m_hold;
        if (m_hold && ack) begin
            m_ready = 0;
            m_digits.delete();
            m_hold = 0;
        end
        if (v) begin
            if (c == 8'hF0) m_brk = 1;
            else if (c == 8'hE0) m_ext = 1;
            else begin
                ks = !m_brk && !m_ext;
                m_brk = 0;
                m_ext = 0;
                if (ks && !was_hold) begin
                    k = key_value(c);
                    if (k >= 0 && k < 16) begin
                        if (m_digits.size() < N) m_digits.push_back(k);
                        else m_err = 1;
                    end else if (k == 16) begin
                        if (m_digits.size() == N) begin
                            m_key = m_buf(); m_ready = 1; m_hold = 1;
                        end else m_err = 1;
                    end else if (k == 17) begin
                        if (m_digits.size() > 0) void'(m_digits.pop_back());
                        else m_err = 1;
                    end else if (k == 18) begin
                        m_digits.delete();
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    endtask

    // One clock: inputs applied, model advanced, outputs sampled 1 time unit after the edge.
    task automatic drive(input logic [7:0] c, input bit v, input bit ack, input bit r);
        scan_code  = c;
        scan_valid = v;
        key_ack    = ack;
        rst        = r;
        model_step(c, v, ack, r);
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        key_ack    = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic byte_in(input logic [7:0] c);
        drive(c, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        drive(8'h16, 1'b1, 1'b1, 1'b1);
        tests_run += 5;
        if (edit_buf !== 16'h0) begin tests_failed++; $display("FAIL reset_edit_buf got %h want 0000", edit_buf); end
        if (digit_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", digit_count); end
        if (key_out !== 16'h0) begin tests_failed++; $display("FAIL reset_key_out got %h want 0000", key_out); end
        if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_key_ready got %b want 0", key_ready); end
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_prefix;
        logic [7:0] seq1[6] = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E};
        logic [7:0] seq2[5] = '{8'hE0, 8'h16, 8'hE0, 8'hF0, 8'h16};
        foreach (seq1[i]) begin
            byte_in(seq1[i]);
            tests_run++;
            if (err !== 1'b0) begin tests_failed++; $display("FAIL prefix_err byte %0d got %b want 0", i, err); end
        end
        tests_run += 2;
        if (edit_buf !== 16'h0012) begin tests_failed++; $display("FAIL prefix_buf got %h want 0012", edit_buf); end
        if (digit_count !== 3'd2) begin tests_failed++; $display("FAIL prefix_count got %0d want 2", digit_count); end
        byte_in(8'h76);
        foreach (seq2[i]) begin
            byte_in(seq2[i]);
            tests_run += 2;
            if (err !== 1'b0) begin tests_failed++; $display("FAIL ext_err byte %0d got %b want 0", i, err); end
            if (edit_buf !== 16'h0) begin tests_failed++; $display("FAIL ext_buf byte %0d got %h want 0000", i, edit_buf); end
        end
        byte_in(8'h16);
        tests_run += 2;
        if (edit_buf !== 16'h0001) begin tests_failed++; $display("FAIL ext_after_buf got %h want 0001", edit_buf); end
        if (digit_count !== 3'd1) begin tests_failed++; $display("FAIL ext_after_count got %0d want 1", digit_count); end
    endtask

    task automatic test_commit;
        byte_in(8'h76);
        byte_in(8'h16); byte_in(8'h1E); byte_in(8'h26); byte_in(8'h25);
        byte_in(8'h45);
        tests_run += 2;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL overflow_err got %b want 1", err); end
        if (edit_buf !== 16'h1234) begin tests_failed++; $display("FAIL overflow_buf got %h want 1234", edit_buf); end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL err_one_cycle got %b want 0", err); end
        byte_in(8'h5A);
        tests_run += 3;
        if (key_out !== 16'h1234) begin tests_failed++; $display("FAIL commit_key got %h want 1234", key_out); end
        if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL commit_ready got %b want 1", key_ready); end
        if (err !== 1'b0) begin tests_failed++; $display("FAIL commit_err got %b want 0", err); end
    endtask

    task automatic test_hold_ack;
        byte_in(8'h16);
        tests_run += 3;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL hold_key_err got %b want 0", err); end
        if (key_out !== 16'h1234) begin tests_failed++; $display("FAIL hold_key_stable got %h want 1234", key_out); end
        if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_ready got %b want 1", key_ready); end
        drive(8'h26, 1'b1, 1'b1, 1'b0);
        tests_run += 4;
        if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL ack_ready got %b want 0", key_ready); end
        if (edit_buf !== 16'h0) begin tests_failed++; $display("FAIL ack_buf got %h want 0000", edit_buf); end
        if (digit_count !== 3'd0) begin tests_failed++; $display("FAIL ack_count got %0d want 0", digit_count); end
        if (err !== 1'b0) begin tests_failed++; $display("FAIL ack_err got %b want 0", err); end
        byte_in(8'h2B);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        tests_run += 2;
        if (edit_buf !== 16'h000F) begin tests_failed++; $display("FAIL edit_ack_buf got %h want 000f", edit_buf); end
        if (digit_count !== 3'd1) begin tests_failed++; $display("FAIL edit_ack_count got %0d want 1", digit_count); end
    endtask

    task automatic test_backspace;
        byte_in(8'h76);
        byte_in(8'h66);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL bksp_empty_err got %b want 1", err); end
        byte_in(8'h1C); byte_in(8'h32); byte_in(8'h66);
        byte_in(8'h5A);
        tests_run += 4;
        if (edit_buf !== 16'h000A) begin tests_failed++; $display("FAIL bksp_buf got %h want 000a", edit_buf); end
        if (digit_count !== 3'd1) begin tests_failed++; $display("FAIL bksp_count got %0d want 1", digit_count); end
        if (err !== 1'b1) begin tests_failed++; $display("FAIL short_enter_err got %b want 1", err); end
        if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL short_enter_ready got %b want 0", key_ready); end
        byte_in(8'h0D);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL undecoded_err got %b want 1", err); end
    endtask

    task automatic test_reset_in_hold;
        byte_in(8'h76);
        byte_in(8'h16); byte_in(8'h1E); byte_in(8'h26); byte_in(8'h25); byte_in(8'h5A);
        byte_in(8'hF0);
        drive(8'h16, 1'b1, 1'b1, 1'b1);
        tests_run += 4;
        if (key_out !== 16'h0) begin tests_failed++; $display("FAIL hold_rst_key got %h want 0000", key_out); end
        if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_rst_ready got %b want 0", key_ready); end
        if (edit_buf !== 16'h0) begin tests_failed++; $display("FAIL hold_rst_buf got %h want 0000", edit_buf); end
        if (digit_count !== 3'd0) begin tests_failed++; $display("FAIL hold_rst_count got %0d want 0", digit_count); end
        byte_in(8'h16); byte_in(8'h1E); byte_in(8'h26); byte_in(8'h25); byte_in(8'h5A);
        tests_run += 2;
        if (key_out !== 16'h1234) begin tests_failed++; $display("FAIL post_rst_key got %h want 1234", key_out); end
        if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_ready got %b want 1", key_ready); end
    endtask

    task automatic test_random;
        logic [7:0] pool[12] = '{8'hF0, 8'hE0, 8'h5A, 8'h66, 8'h76, 8'h45,
                                 8'h16, 8'h2B, 8'h3E, 8'h1C, 8'h24, 8'h29};
        logic [7:0] c;
        bit v, a, r;
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) c = 8'($urandom);
            else c = pool[$urandom_range(0, 11)];
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 99) == 0);
            drive(c, v, a, r);
            tests_run += 5;
            if (edit_buf !== m_buf()) begin tests_failed++; $display("FAIL rnd_buf cyc %0d got %h want %h", i, edit_buf, m_buf()); end
            if (digit_count !== 3'(m_digits.size())) begin tests_failed++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, digit_count, m_digits.size()); end
            if (key_out !== m_key) begin tests_failed++; $display("FAIL rnd_key cyc %0d got %h want %h", i, key_out, m_key); end
            if (key_ready !== m_ready) begin tests_failed++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, key_ready, m_ready); end
            if (err !== m_err) begin tests_failed++; $display("FAIL rnd_err cyc %0d got %b want %b", i, err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_prefix();
        test_commit();
        test_hold_ack();
        test_backspace();
        test_reset_in_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
